axis_burst_framer: RTL and testbench

AXIS_BURST_FRAMER -- requirements
Module: axis_burst_framer

---
 rtl/axis_burst_framer.sv | 81 ++++++++
 tb/tb_axis_burst_framer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/axis_burst_framer.sv
// axis_burst_framer: groups an AXI-Stream word flow into bursts of up to BURST beats,
// closing a partial burst after TIMEOUT idle cycles or on flush_i.
//   clock, reset_n         : clock and asynchronous active-low reset
//   s_tvalid/s_tready/s_tdata : upstream words (FIFO read side)
//   m_tvalid/m_tready/m_tlast/m_tdata : framed output stream
//   flush_i                : force-close the burst containing the held word
//   busy_o                 : a word is held or being output
module axis_burst_framer #(
    parameter int WIDTH   = 8,
    parameter int BURST   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [WIDTH-1:0] m_tdata,
    input  logic             flush_i,
    output logic             busy_o
);
    localparam int BW = $clog2(BURST) + 1;
    localparam int IW = $clog2(TIMEOUT) + 1;
    localparam logic [BW-1:0] BEAT_MAX = BW'(BURST - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

    logic             hvalid_q, hvalid_d;
    logic [WIDTH-1:0] hdata_q, hdata_d;
    logic             m_tvalid_q, m_tvalid_d;
    logic             m_tlast_q, m_tlast_d;
    logic [WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic             ofree, accept, close, promote;

    always_comb begin
        ofree    = !m_tvalid_q || m_tready;
        // Gated by reset_n so upstream sees no accept while reset is asserted.
        s_tready = reset_n && (!hvalid_q || ofree);
        accept   = s_tvalid && s_tready;
        close    = beat_q == BEAT_MAX || idle_q == IDLE_MAX || flush_i;
        // The held word leaves only once its successor arrives or the burst closes,
        // so the last flag is always known at promotion time.
        promote  = hvalid_q && ofree && (s_tvalid || close);
        hvalid_d   = accept ? 1'b1 : (promote ? 1'b0 : hvalid_q);
        hdata_d    = accept ? s_tdata : hdata_q;
        m_tvalid_d = promote ? 1'b1 : (m_tready ? 1'b0 : m_tvalid_q);
        m_tdata_d  = promote ? hdata_q : m_tdata_q;
        m_tlast_d  = promote ? close : m_tlast_q;
        beat_d     = promote ? (close ? '0 : beat_q + 1'b1) : beat_q;
        idle_d     = (accept || !hvalid_q) ? '0 : (idle_q == IDLE_MAX ? idle_q : idle_q + 1'b1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hvalid_q   <= 1'b0;
            hdata_q    <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tdata_q  <= '0;
            beat_q     <= '0;
            idle_q     <= '0;
        end else begin
            hvalid_q   <= hvalid_d;
            hdata_q    <= hdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tdata_q  <= m_tdata_d;
            beat_q     <= beat_d;
            idle_q     <= idle_d;
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign m_tdata  = m_tdata_q;
    assign busy_o   = hvalid_q || m_tvalid_q;
endmodule

// File: tb/tb_axis_burst_framer.sv
// tb_axis_burst_framer: directed and randomized checks of axis_burst_framer against a queue-based model.
module tb_axis_burst_framer;
    localparam int WIDTH = 8, BURST = 4, TIMEOUT = 3;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             s_tvalid = 1'b0, s_tready;
    logic [WIDTH-1:0] s_tdata = '0;
    logic             m_tvalid, m_tready = 1'b0, m_tlast;
    logic [WIDTH-1:0] m_tdata;
    logic             flush_i = 1'b0, busy_o;

    axis_burst_framer #(.WIDTH(WIDTH), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
        .flush_i(flush_i), .busy_o(busy_o)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the word waiting for its successor, the word on the output,
    // how many beats of the current burst have been emitted, and cycles since last arrival.
    logic [WIDTH-1:0] held[$];
    bit               ov, ol;
    logic [WIDTH-1:0] od;
    int               beats, gap;
    int               n_in, n_out;

    task automatic model_reset();
        held.delete();
        ov = 0; ol = 0; od = '0; beats = 0; gap = 0;
    endtask

    // One clock cycle: drive inputs, check DUT against model, advance model, cross the edge.
    task automatic cyc(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit f);
        bit free, sr, acc, fin, prom, had;
        s_tvalid = v; s_tdata = d; m_tready = r; flush_i = f;
        #1;
        had  = held.size() > 0;
        free = !ov || r;
        sr   = !had || free;
        acc  = v && sr;
        fin  = had && (beats == BURST - 1 || gap >= TIMEOUT || f);
        prom = had && free && (v || fin);
        chk("m_tvalid", m_tvalid, ov);
        if (ov) begin
            chk("m_tdata", m_tdata, od);
            chk("m_tlast", m_tlast, ol);
        end
        chk("s_tready", s_tready, sr);
        chk("busy_o", busy_o, had || ov);
        if (ov && r) n_out++;
        if (prom) begin
            od = held.pop_front();
            ov = 1; ol = fin;
            beats = fin ? 0 : beats + 1;
        end else if (r) ov = 0;
        gap = (acc || !had) ? 0 : gap + 1;
        if (acc) begin
            held.push_back(d);
            n_in++;
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 1, 0);
    endtask

    initial begin
        model_reset();
        n_in = 0; n_out = 0;
        @(negedge clock);
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_busy", busy_o, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // back-to-back burst of 8 with free output
        for (int i = 0; i < 8; i++) cyc(1, WIDTH'(8'h10 + i), 1, 0);
        idle(8);

        // partial burst closed by timeout, then a fresh burst
        cyc(1, 8'hA0, 1, 0);
        cyc(1, 8'hA1, 1, 0);
        idle(7);
        cyc(1, 8'hB0, 1, 0);
        idle(7);

        // output stalled for 10 cycles mid-stream
        for (int i = 0; i < 8; i++) begin
            if (i == 3) for (int k = 0; k < 10; k++) cyc(1, WIDTH'(8'h20 + i), 0, 0);
            cyc(1, WIDTH'(8'h20 + i), 1, 0);
        end
        idle(8);

        // flush with a word held and the next word arriving
        cyc(1, 8'h55, 1, 0);
        cyc(1, 8'h56, 1, 1);
        idle(8);

        // randomized traffic with varying densities
        for (int blk = 0; blk < 30; blk++) begin
            int pv, pr;
            pv = $urandom_range(1, 10);
            pr = $urandom_range(2, 10);
            for (int i = 0; i < 80; i++)
                cyc($urandom_range(0, 9) < pv, WIDTH'($urandom), $urandom_range(0, 9) < pr,
                    $urandom_range(0, 19) == 0);
        end
        idle(10);
        chk("no_loss", n_out, n_in);

        // asynchronous reset mid-burst
        cyc(1, 8'h60, 1, 0);
        cyc(1, 8'h61, 0, 0);
        cyc(1, 8'h62, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_m_tvalid", m_tvalid, 0);
        chk("arst_s_tready", s_tready, 0);
        chk("arst_busy", busy_o, 0);
        model_reset();
        s_tvalid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1, WIDTH'(8'h30 + i), 1, 0);
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
